// File: rtl/cut_error_monitor_if.sv
// Host and cell-side signals of the CUT error monitor, grouped as one bundle.
// The monitor takes the slave view; the host/cell model takes the master view.
interface cut_error_monitor_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             diff_in;
   logic             data_out;
   logic             clear_diff;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] err_count;
   logic             err_any;

   modport master (
      output start, diff_in,
      input  data_out, clear_diff, busy, done, err_count, err_any
   );

   modport slave (
      input  start, diff_in,
      output data_out, clear_diff, busy, done, err_count, err_any
   );
endinterface

// File: rtl/cut_error_monitor.sv
// Toggle-stimulus sequencer for one timing cell: clear flag, toggle, settle,
// sample the sticky mismatch flag, and keep a saturating count of failures.
module cut_error_monitor #(
   parameter int WINDOW_LEN    = 1024,
   parameter int SETTLE_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input logic                fast_clk,
   input logic                rst_n,
   cut_error_monitor_if.slave bus
);
   localparam int TCNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
   localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(WINDOW_LEN - 1);
   localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, TOGGLE, SETTLE, CHECK, DONE} state_t;

   state_t            state, state_nxt;
   logic [TCNT_W-1:0] tcnt;
   logic [SCNT_W-1:0] scnt;
   logic              data_q;
   logic              clear_q;
   logic [CNT_W-1:0]  err_q;
   logic              any_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CLEAR;
         CLEAR:   state_nxt = TOGGLE;
         TOGGLE:  state_nxt = SETTLE;
         SETTLE:  if (scnt == '0) state_nxt = CHECK;
         CHECK:   state_nxt = (tcnt == TCNT_LAST) ? DONE : CLEAR;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge fast_clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         tcnt    <= '0;
         scnt    <= '0;
         data_q  <= 1'b0;
         clear_q <= 1'b0;
         err_q   <= '0;
         any_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         // Registered so the cell sees a glitch-free one-cycle clear in CLEAR.
         clear_q <= (state_nxt == CLEAR);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  err_q <= '0;
                  any_q <= 1'b0;
                  tcnt  <= '0;
                  scnt  <= '0;
               end
            end
            TOGGLE: begin
               data_q <= ~data_q;
               scnt   <= SCNT_INIT;
            end
            SETTLE: begin
               if (scnt != '0) scnt <= scnt - SCNT_W'(1);
            end
            CHECK: begin
               if (bus.diff_in && (err_q != '1)) begin
                  err_q <= err_q + CNT_W'(1);
                  any_q <= 1'b1;
               end
               if (tcnt != TCNT_LAST) tcnt <= tcnt + TCNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.data_out   = data_q;
   assign bus.clear_diff = clear_q;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.err_count  = err_q;
   assign bus.err_any    = any_q;
endmodule

// File: tb/tb_cut_error_monitor.sv
// Two monitors (W=4/S=2/16-bit count and W=6/S=2/2-bit count) share stimulus and
// are compared every cycle against a run-position model, plus literal pins.
module tb_cut_error_monitor;
   logic fast_clk = 1'b0;
   logic rst_n    = 1'b0;
   logic start    = 1'b0;
   logic diff     = 1'b0;

   always #5 fast_clk = ~fast_clk;

   cut_error_monitor_if #(.CNT_W(16)) bus_a ();
   cut_error_monitor_if #(.CNT_W(2))  bus_b ();

   assign bus_a.start   = start;
   assign bus_a.diff_in = diff;
   assign bus_b.start   = start;
   assign bus_b.diff_in = diff;

   cut_error_monitor #(.WINDOW_LEN(4), .SETTLE_CYCLES(2), .CNT_W(16)) dut_a (
      .fast_clk(fast_clk), .rst_n(rst_n), .bus(bus_a.slave));
   cut_error_monitor #(.WINDOW_LEN(6), .SETTLE_CYCLES(2), .CNT_W(2)) dut_b (
      .fast_clk(fast_clk), .rst_n(rst_n), .bus(bus_b.slave));

   logic [1:0]       o_busy, o_done, o_clr, o_data, o_any;
   logic [1:0][15:0] o_cnt;
   assign o_busy = {bus_b.busy, bus_a.busy};
   assign o_done = {bus_b.done, bus_a.done};
   assign o_clr  = {bus_b.clear_diff, bus_a.clear_diff};
   assign o_data = {bus_b.data_out, bus_a.data_out};
   assign o_any  = {bus_b.err_any, bus_a.err_any};
   assign o_cnt  = {{14'b0, bus_b.err_count}, bus_a.err_count};

   int W_P[2] = '{4, 6};
   int S_P[2] = '{2, 2};
   int MX[2]  = '{65535, 3};

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int acc   = 0;

   // Model: position k within the run decides everything.
   bit m_run[2];
   int m_k[2];
   bit m_data[2];
   int m_cnt[2];
   int ml, mp;

   task automatic chk(input string nm, input int d, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s[%0d] at cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
      end
   endtask

   always @(posedge fast_clk) begin
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
         ml = W_P[d] * (S_P[d] + 3);
         if (!rst_n) begin
            m_run[d] = 0; m_k[d] = 0; m_data[d] = 0; m_cnt[d] = 0;
         end else if (!m_run[d]) begin
            if (start) begin m_run[d] = 1; m_k[d] = 0; m_cnt[d] = 0; end
         end else if (m_k[d] == ml) begin
            m_run[d] = 0;
         end else begin
            mp = m_k[d] % (S_P[d] + 3);
            if (mp == 1) m_data[d] = !m_data[d];
            if (mp == S_P[d] + 2 && diff && m_cnt[d] < MX[d]) m_cnt[d]++;
            m_k[d]++;
         end
      end
   end

   int  cl, e_len;
   int  done_at[2] = '{-1, -1};
   int  tog[2]     = '{0, 0};
   int  clr[2]     = '{0, 0};
   bit  prev_d[2];

   always @(negedge fast_clk) begin
      for (int d = 0; d < 2; d++) begin
         e_len = W_P[d] * (S_P[d] + 3);
         cl    = S_P[d] + 3;
         chk("busy", d, int'(o_busy[d]), int'(m_run[d]));
         chk("done", d, int'(o_done[d]), int'(m_run[d] && m_k[d] == e_len));
         chk("clear_diff", d, int'(o_clr[d]),
             int'(m_run[d] && m_k[d] < e_len && (m_k[d] % cl) == 0));
         chk("data_out", d, int'(o_data[d]), int'(m_data[d]));
         chk("err_count", d, int'(o_cnt[d]), m_cnt[d]);
         chk("err_any", d, int'(o_any[d]), int'(m_cnt[d] != 0));
         if (o_done[d]) done_at[d] = cyc - acc;
         if (o_clr[d]) clr[d]++;
         if (o_data[d] != prev_d[d]) tog[d]++;
         prev_d[d] = o_data[d];
      end
   end

   task automatic tick();
      @(negedge fast_clk);
      #1;
   endtask

   int tg0[2], cl0[2];

   task automatic pulse_start();
      start   = 1'b1;
      acc     = cyc + 1;
      done_at = '{-1, -1};
      tg0     = tog;
      cl0     = clr;
      tick();
   endtask

   // mode 0: diff low, 1: high in 2nd/4th CHECK of dut_a, 2: high, 3: random
   task automatic run(input int mode, input int start_at, input int rst_at);
      int k;
      pulse_start();
      for (int i = 0; i < 200; i++) begin
         k     = cyc - acc;
         diff  = (mode == 0) ? 1'b0 : (mode == 1) ? (k == 9 || k == 19) :
                 (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         start = (k == start_at);
         rst_n = (k != rst_at);
         if (k == rst_at + 1) return;
         if (k > 0 && !o_busy[0] && !o_busy[1]) begin
            diff = 1'b0; start = 1'b0;
            return;
         end
         tick();
      end
      chk("run_timeout", 0, 1, 0);
   endtask

   task automatic check_idle_zero(input string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_busy"}, d, int'(o_busy[d]), 0);
         chk({nm, "_data"}, d, int'(o_data[d]), 0);
         chk({nm, "_cnt"}, d, int'(o_cnt[d]), 0);
         chk({nm, "_any"}, d, int'(o_any[d]), 0);
         chk({nm, "_clr"}, d, int'(o_clr[d]), 0);
         chk({nm, "_done"}, d, int'(o_done[d]), 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check_idle_zero("idle");

      // clean window
      run(0, -1, -5);
      chk("done_at", 0, done_at[0], 20);
      chk("done_at", 1, done_at[1], 30);
      chk("toggles", 0, tog[0] - tg0[0], 4);
      chk("clears", 0, clr[0] - cl0[0], 4);
      chk("toggles", 1, tog[1] - tg0[1], 6);
      chk("end_data", 0, int'(o_data[0]), 0);
      chk("clean_cnt", 0, int'(o_cnt[0]), 0);

      // failures in the 2nd and 4th CHECK, then held while idle
      run(1, -1, -5);
      chk("pat_cnt", 0, int'(o_cnt[0]), 2);
      chk("pat_any", 0, int'(o_any[0]), 1);
      for (int i = 0; i < 10; i++) tick();
      chk("hold_cnt", 0, int'(o_cnt[0]), 2);
      chk("hold_any", 0, int'(o_any[0]), 1);

      // always failing: 2-bit counter saturates at 3
      run(2, -1, -5);
      chk("sat_cnt", 1, int'(o_cnt[1]), 3);
      chk("sat_done_at", 1, done_at[1], 30);
      chk("full_cnt", 0, int'(o_cnt[0]), 4);

      // start during SETTLE is ignored
      run(3, 2, -5);
      chk("ign_done_at", 0, done_at[0], 20);
      chk("ign_clears", 0, clr[0] - cl0[0], 4);

      // reset in iteration 2 aborts, then a clean window
      run(3, -1, 7);
      check_idle_zero("abort");
      chk("abort_done", 0, done_at[0], -1);
      chk("abort_done", 1, done_at[1], -1);
      run(3, -1, -5);
      chk("rerun_done_at", 0, done_at[0], 20);
      chk("rerun_done_at", 1, done_at[1], 30);

      // random runs with stray start pulses
      for (int r = 0; r < 6; r++) run(3, int'($urandom_range(1, 25)), -5);

      // start held high re-arms straight out of DONE
      start = 1'b1;
      acc   = cyc + 1;
      for (int i = 0; i < 70; i++) begin
         diff = 1'($urandom_range(0, 1));
         tick();
      end
      start = 1'b0;
      diff  = 1'b0;
      begin
         int n;
         n = 0;
         while ((o_busy[0] || o_busy[1]) && n < 100) begin tick(); n++; end
         chk("hold_timeout", 0, int'(n >= 100), 0);
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cut_error_monitor.md
# cut_error_monitor

Test sequencer and error collector for a single circuit-under-test timing cell. It drives the cell's data input with a toggling stimulus and clears the cell's sticky mismatch flag before each toggle. After a settle interval it samples the flag and counts the toggles that produced a capture mismatch. It runs in the `fast_clk` domain and connects directly to the cell's `data_in`, `clear_diff` and `diff` pins; the host reads the resulting count.

## Interface
Parameters:
- `WINDOW_LEN`, default 1024: number of toggles per test run. Must be ≥ 1.
- `SETTLE_CYCLES`, default 8: `fast_clk` cycles between a toggle and the `diff` sample.
  - Must be ≥ 1.
  - The integrator sets it so that it covers at least one full `normal_clk` period plus 2 cycles.
- `CNT_W`, default 16: width of the error counter.

Ports (one clock; reset is synchronous and active-low):
- `fast_clk` in 1: sole clock. All state updates on its rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: level-sampled run request. Accepted only in IDLE.
- `diff_in` in 1: sticky mismatch flag from the cell, already registered in `fast_clk`. No synchroniser.
- `data_out` out 1: stimulus to the cell's `data_in`. Registered.
- `clear_diff` out 1: clear request to the cell. Registered.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is exited.
- `done` out 1: one-cycle pulse at end of run.
- `err_count` out `CNT_W`: number of toggles with `diff_in` = 1 at CHECK. Saturating.
- `err_any` out 1: high if `err_count` ≠ 0.

## Operation
States: IDLE, CLEAR, TOGGLE, SETTLE, CHECK, DONE.

- **IDLE:** `busy` = 0, `clear_diff` = 0.
  - On `start` = 1: clear `err_count`, `err_any`, the toggle counter `tcnt` and the settle counter; go to CLEAR.
  - `data_out` keeps its last value.
- **CLEAR:** `clear_diff` = 1 for exactly this one cycle; go to TOGGLE.
- **TOGGLE:** at the exit edge, `data_out` <= ~`data_out` and `scnt` <= `SETTLE_CYCLES`-1; go to SETTLE.
- **SETTLE:** decrement `scnt`; go to CHECK at the edge where `scnt` = 0.
- **CHECK:** sample `diff_in`.
  - If it is 1 and `err_count` ≠ all-ones, increment `err_count` and set `err_any`.
  - If `tcnt` = `WINDOW_LEN`-1, go to DONE. Otherwise `tcnt`++ and go to CLEAR.
- **DONE:** `done` = 1 for this one cycle; go to IDLE.

General rules:
- Outputs are Moore-decoded from registered state, or are registers themselves.
- `err_count` and `err_any` hold their values from DONE until the next accepted `start`.
- `start` is ignored in every state except IDLE. No queuing of requests.
- `tcnt` width is $clog2(`WINDOW_LEN`), minimum 1. `scnt` width is $clog2(`SETTLE_CYCLES`), minimum 1.
- Saturation: `err_count` stops at 2^`CNT_W`-1. It never wraps.

## Timing
Reset:
- On an `fast_clk` edge with `rst_n` = 0, the block enters IDLE and sets `data_out` = 0, `clear_diff` = 0, `busy` = 0, `done` = 0, `err_count` = 0, `err_any` = 0, and all counters to 0.
- Reset mid-run aborts with no `done` pulse.

Run timing:
- Let the edge at which `start` is sampled in IDLE be edge 0.
- CLEAR occupies the cycle after edge 0.
- Each toggle iteration takes exactly `SETTLE_CYCLES`+3 cycles: CLEAR 1, TOGGLE 1, SETTLE `SETTLE_CYCLES`, CHECK 1.
- `done` is high in the cycle that begins `WINDOW_LEN`*(`SETTLE_CYCLES`+3) edges after edge 0.
- `busy` falls in the same cycle IDLE is re-entered, which is the cycle after `done`.

Stimulus and sampling:
- `data_out` changes exactly once per iteration, on the TOGGLE→SETTLE edge.
- After an even `WINDOW_LEN`, `data_out` ends equal to its value at start.
- `diff_in` is sampled only in CHECK. Flag activity in any other state is ignored.
- `start` held high through DONE re-arms immediately: accepted on the first IDLE cycle.

## Test plan
- Reset, then idle with `start` = 0 for 20 cycles -> all outputs 0, state IDLE, `data_out` stable at 0.
- `WINDOW_LEN` = 4, `SETTLE_CYCLES` = 2, `diff_in` tied 0, `start` pulsed 1 cycle -> `done` at edge 20 after acceptance.
  - `err_count` = 0, `err_any` = 0.
  - `data_out` toggles 4 times and ends at 0.
  - `clear_diff` pulses 4 times, each 1 cycle.
- Same parameters, `diff_in` = 1 only during the 2nd and 4th CHECK -> `err_count` = 2, `err_any` = 1 after `done`.
  - These values are held until the next `start`.
- `CNT_W` = 2, `WINDOW_LEN` = 6, `diff_in` tied 1 -> `err_count` saturates at 3 and does not wrap to 0. `done` still arrives on schedule.
- Pulse `start` during SETTLE of a run -> ignored. Run length and count unchanged.
- Assert `rst_n` = 0 for 1 cycle during iteration 2 -> next cycle IDLE, all outputs at reset values, no `done` pulse.
  - A new `start` then runs a full clean window.
